// File: rtl/counter_pkg.sv
// Shared definitions for the cascaded modulo counter: direction encoding and
// the parameter sanity check used at elaboration.
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // True when a digit of width w can hold every value 0..m-1 and m is a usable modulus.
    function automatic bit digit_w_ok(input int w, input int m);
        return (m >= 2) && (w >= 1) && ((64'd1 << w) >= 64'(m));
    endfunction

endpackage

// File: rtl/mod_cascade_counter_digit.sv
// One modulo-DIGIT_MOD digit of the cascade. Also exposes its next-state value so
// the top can register a zero-latency compare match.
module mod_digit
    import counter_pkg::*;
#(
    parameter int DIGIT_W   = 4,
    parameter int DIGIT_MOD = 10
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               step,
    input  logic               up_dn,
    input  logic               clr,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_digit,
    input  logic               hold,
    output logic [DIGIT_W-1:0] value,
    output logic [DIGIT_W-1:0] value_next,
    output logic               at_max,
    output logic               at_zero
);

    localparam logic [DIGIT_W-1:0] DIGIT_MAX = DIGIT_W'(DIGIT_MOD - 1);

    logic [DIGIT_W-1:0] value_q;
    logic [DIGIT_W-1:0] value_d;

    assign at_max     = (value_q == DIGIT_MAX);
    assign at_zero    = (value_q == '0);
    assign value      = value_q;
    assign value_next = value_d;

    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = '0;
        end else if (load) begin
            value_d = (load_digit > DIGIT_MAX) ? DIGIT_MAX : load_digit;
        end else if (step && !hold) begin
            if (up_dn == DIR_UP) begin
                value_d = at_max ? '0 : value_q + DIGIT_W'(1);
            end else begin
                value_d = at_zero ? DIGIT_MAX : value_q - DIGIT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

endmodule

// File: rtl/mod_cascade_counter.sv
// Multi-digit cascaded modulo counter with up/down, load/clear, one-shot stop,
// registered compare match and terminal-count outputs.
module mod_cascade_counter
    import counter_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DIGIT_MOD  = 10,
    parameter int DIGIT_W    = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          en,
    input  logic                          up_dn,
    input  logic                          clr,
    input  logic                          load,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] load_val,
    input  logic                          oneshot,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] cmp_val,
    output logic [NUM_DIGITS*DIGIT_W-1:0] cnt,
    output logic                          cout,
    output logic                          tc,
    output logic                          match,
    output logic                          done
);

    localparam int W = NUM_DIGITS * DIGIT_W;

    if (!digit_w_ok(DIGIT_W, DIGIT_MOD) || (NUM_DIGITS < 1)) begin : g_param_check
        $error("mod_cascade_counter: DIGIT_W too small for DIGIT_MOD, or NUM_DIGITS < 1");
    end

    logic [NUM_DIGITS-1:0] at_max;
    logic [NUM_DIGITS-1:0] at_zero;
    logic [NUM_DIGITS-1:0] step;
    logic [W-1:0]          cnt_next;
    logic                  count_ok;
    logic                  wrap;
    logic                  hold;

    logic cout_q, cout_d;
    logic done_q, done_d;
    logic match_q, match_d;

    assign count_ok = en & ~done_q;
    assign tc       = (up_dn == DIR_UP) ? (&at_max) : (&at_zero);
    assign wrap     = en & tc & ~done_q & ~clr & ~load;
    // In one-shot mode the terminal value freezes instead of rolling over.
    assign hold     = oneshot & tc;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        if (i == 0) begin : g_lsd
            assign step[i] = count_ok;
        end else begin : g_upper
            assign step[i] = count_ok &
                ((up_dn == DIR_UP) ? (&at_max[i-1:0]) : (&at_zero[i-1:0]));
        end

        mod_digit #(
            .DIGIT_W   (DIGIT_W),
            .DIGIT_MOD (DIGIT_MOD)
        ) u_digit (
            .clk        (clk),
            .rstn       (rstn),
            .step       (step[i]),
            .up_dn      (up_dn),
            .clr        (clr),
            .load       (load),
            .load_digit (load_val[i*DIGIT_W +: DIGIT_W]),
            .hold       (hold),
            .value      (cnt[i*DIGIT_W +: DIGIT_W]),
            .value_next (cnt_next[i*DIGIT_W +: DIGIT_W]),
            .at_max     (at_max[i]),
            .at_zero    (at_zero[i])
        );
    end

    always_comb begin
        cout_d  = 1'b0;
        done_d  = done_q;
        match_d = (cnt_next == cmp_val);
        if (clr || load) begin
            done_d = 1'b0;
        end else if (wrap) begin
            cout_d = 1'b1;
            done_d = done_q | oneshot;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
            match_q <= 1'b0;
        end else begin
            cout_q  <= cout_d;
            done_q  <= done_d;
            match_q <= match_d;
        end
    end

    assign cout  = cout_q;
    assign done  = done_q;
    assign match = match_q;

endmodule

// File: tb/tb_mod_cascade_counter.sv
// Self-checking bench for a two-digit BCD cascade counter against an integer
// reference model of the counting rules.
module tb_mod_cascade_counter;

    localparam int ND   = 2;
    localparam int DM   = 10;
    localparam int DW   = 4;
    localparam int W    = ND * DW;
    localparam int MAXV = DM ** ND - 1;

    logic         clk = 1'b0;
    logic         rstn;
    logic         en, up_dn, clr, load, oneshot;
    logic [W-1:0] load_val, cmp_val;
    logic [W-1:0] cnt;
    logic         cout, tc, match, done;

    int total = 0;
    int bad   = 0;

    int mCnt;
    bit mCout, mDone, mMatch;

    mod_cascade_counter #(
        .NUM_DIGITS (ND),
        .DIGIT_MOD  (DM),
        .DIGIT_W    (DW)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .en       (en),
        .up_dn    (up_dn),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .oneshot  (oneshot),
        .cmp_val  (cmp_val),
        .cnt      (cnt),
        .cout     (cout),
        .tc       (tc),
        .match    (match),
        .done     (done)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] toBcd(input int v);
        logic [W-1:0] r;
        int           x;
        r = '0;
        x = v;
        for (int i = 0; i < ND; i++) begin
            r[i*DW +: DW] = DW'(x % DM);
            x = x / DM;
        end
        return r;
    endfunction

    // Integer value of a load word, each digit saturated at DM-1.
    function automatic int clampedValue(input logic [W-1:0] x);
        int acc;
        int d;
        acc = 0;
        for (int i = ND - 1; i >= 0; i--) begin
            d = int'(x[i*DW +: DW]);
            if (d > DM - 1) d = DM - 1;
            acc = acc * DM + d;
        end
        return acc;
    endfunction

    task automatic checkVal(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        checkVal("cnt",   cnt,       toBcd(mCnt));
        checkVal("cout",  W'(cout),  W'(mCout));
        checkVal("done",  W'(done),  W'(mDone));
        checkVal("match", W'(match), W'(mMatch));
        checkVal("tc",    W'(tc),    W'(up_dn ? (mCnt == MAXV) : (mCnt == 0)));
    endtask

    task automatic modelReset();
        mCnt   = 0;
        mCout  = 1'b0;
        mDone  = 1'b0;
        mMatch = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic modelEdge();
        bit atEnd;
        mCout = 1'b0;
        if (clr) begin
            mCnt  = 0;
            mDone = 1'b0;
        end else if (load) begin
            mCnt  = clampedValue(load_val);
            mDone = 1'b0;
        end else if (en && !mDone) begin
            atEnd = up_dn ? (mCnt == MAXV) : (mCnt == 0);
            if (atEnd) begin
                mCout = 1'b1;
                if (oneshot) mDone = 1'b1;
                else         mCnt  = up_dn ? 0 : MAXV;
            end else begin
                mCnt = up_dn ? mCnt + 1 : mCnt - 1;
            end
        end
        mMatch = (toBcd(mCnt) === cmp_val);
    endtask

    task automatic applyStimulus(input logic iEn, input logic iUp, input logic iClr,
                                 input logic iLoad, input logic [W-1:0] iLv,
                                 input logic iOs, input logic [W-1:0] iCmp);
        en       = iEn;
        up_dn    = iUp;
        clr      = iClr;
        load     = iLoad;
        load_val = iLv;
        oneshot  = iOs;
        cmp_val  = iCmp;
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput();
    endtask

    initial begin
        int pulses;
        logic [W-1:0] rndCmp;
        logic rUp, rOs;

        rstn = 1'b0; en = 1'b0; up_dn = 1'b1; clr = 1'b0; load = 1'b0;
        oneshot = 1'b0; load_val = '0; cmp_val = 8'h77;
        modelReset();
        #12;
        checkVal("reset_cnt",  cnt,       '0);
        checkVal("reset_cout", W'(cout),  '0);
        checkVal("reset_done", W'(done),  '0);
        checkVal("reset_match", W'(match), '0);
        rstn = 1'b1;

        $display("[TB] full up count through wrap");
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1, 1, 0, 0, '0, 0, 8'h77);
            if (cout) pulses++;
        end
        checkVal("up_wrap_cnt", cnt, 8'h00);
        checkVal("up_wrap_pulses", W'(pulses), W'(1));

        $display("[TB] down count through wrap");
        applyStimulus(0, 0, 0, 1, 8'h05, 0, 8'h77);
        for (int i = 0; i < 7; i++) applyStimulus(1, 0, 0, 0, '0, 0, 8'h77);

        $display("[TB] one-shot stop");
        applyStimulus(0, 1, 0, 1, 8'h97, 1, 8'h77);
        for (int i = 0; i < 5; i++) applyStimulus(1, 1, 0, 0, '0, 1, 8'h77);
        checkVal("oneshot_hold", cnt, 8'h99);
        applyStimulus(1, 1, 1, 0, '0, 1, 8'h77);

        $display("[TB] clamped load and priorities");
        applyStimulus(0, 1, 0, 1, 8'hAF, 0, 8'h77);
        checkVal("clamp_cnt", cnt, 8'h99);
        applyStimulus(1, 1, 1, 1, 8'h33, 0, 8'h77);
        checkVal("clr_wins", cnt, 8'h00);
        applyStimulus(1, 1, 0, 1, 8'h33, 0, 8'h77);
        checkVal("load_wins", cnt, 8'h33);

        $display("[TB] compare match and async reset");
        applyStimulus(0, 1, 0, 1, 8'h40, 0, 8'h42);
        for (int i = 0; i < 17; i++) applyStimulus(1, 1, 0, 0, '0, 0, 8'h42);
        checkVal("pre_reset_cnt", cnt, 8'h57);
        #3 rstn = 1'b0;
        modelReset();
        #1;
        checkVal("async_cnt",  cnt,      '0);
        checkVal("async_cout", W'(cout), '0);
        checkVal("async_done", W'(done), '0);
        #2 rstn = 1'b1;

        $display("[TB] randomized traffic");
        rUp = 1'b1;
        rOs = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) rUp = ~rUp;
            if ($urandom_range(0, 14) == 0) rOs = ~rOs;
            rndCmp = ($urandom_range(0, 1) == 0) ? toBcd($urandom_range(0, MAXV))
                                                 : toBcd((mCnt + 1) % (MAXV + 1));
            applyStimulus(logic'($urandom_range(0, 7) != 0), rUp,
                          logic'($urandom_range(0, 39) == 0),
                          logic'($urandom_range(0, 19) == 0),
                          W'($urandom_range(0, 255)), rOs, rndCmp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
